axis_tx_sched_64: RTL and testbench
===================================

Name: axis_tx_sched_64

Overview:
- Frame-granular round-robin scheduler sharing one 64-bit AXI-stream TX path (10G MAC TX FIFO input) between N requesters, e.g. loopback FIFO, test-pattern generator and management responder.
- Holds a grant for a whole frame (until tlast) so frames are never interleaved.
- Sits between the requester FIFOs and the eth_mac_10g_fifo tx_axis port, in the clk domain.

Parameters:
- PORTS, 4, number of requesters (2..8).
- DATA_WIDTH, 64, tdata width.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.

Ports:
- clk  in  1  core clock (156.25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- input_axis_tdata  in  PORTS*DATA_WIDTH  packed per-port data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- input_axis_tkeep  in  PORTS*KEEP_WIDTH  packed per-port byte enables.
- input_axis_tvalid  in  PORTS  per-port valid.
- input_axis_tready  out  PORTS  per-port ready.
- input_axis_tlast  in  PORTS  per-port end of frame.
- input_axis_tuser  in  PORTS  per-port bad-frame flag.
- output_axis_tdata  out  DATA_WIDTH  to MAC TX.
- output_axis_tkeep  out  KEEP_WIDTH.
- output_axis_tvalid  out  1.
- output_axis_tready  in  1.
- output_axis_tlast  out  1.
- output_axis_tuser  out  1.
- grant_active  out  1  a frame is in progress.
- grant_port  out  3  index of the current or last granted port.

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0.
  - input_axis_tready = 0.
  - FSM = IDLE.
  - RR pointer = 0, so port 0 has highest priority first.
- FSM has two states: IDLE and XFER.
- IDLE:
  - Requests are input_axis_tvalid bits.
  - If any request is set, pick the first requesting port at or after the RR pointer, wrapping modulo PORTS.
  - Register grant_port, set grant_active = 1, move to XFER.
  - Request-to-first-ready latency is 1 cycle.
  - No request: remain in IDLE, all tready = 0.
- XFER:
  - input_axis_tready[grant_port] = (~output_axis_tvalid | output_axis_tready); all other tready bits = 0.
  - On an input handshake, the beat (tdata/tkeep/tlast/tuser) is loaded into the output register. There is one register stage, so input-to-output latency is 1 cycle.
  - Output register clears valid when output_axis_tready is high and no new beat is loaded.
  - A full-throughput stream sustains 1 beat/cycle.
  - On a handshake with tlast = 1:
    - RR pointer = grant_port + 1, wrapping PORTS-1 -> 0.
    - grant_active = 0, FSM -> IDLE.
  - grant_port holds its value after the frame ends.
  - This gives 1 idle input cycle between frames; the MAC IFG absorbs it.
- Output stall: the output register holds a stable beat while output_axis_tvalid & ~output_axis_tready; AXI-stream rules apply.
- Granted port deasserts tvalid mid-frame: the grant is held, no timeout, and no beat is emitted until the port resumes.
- Another port asserts valid during XFER: ignored until the grant returns to IDLE.
- Simultaneous tlast handshake and new requests: the new requests are seen in IDLE on the next cycle; arbitration uses the updated pointer.
- Single-beat frame (tlast on first beat): valid; the grant lasts exactly 1 handshake.
- tuser passes through unmodified; the MAC drops the frame.
- Reset mid-frame: outputs clear immediately.
  - A partial frame may already be in the MAC FIFO; the MAC FIFO also resets in the same reset domain.

Optional Feature:
- AXIS_TX_SCHED_STATS_EN defined:
  - Adds output port frame_count, PORTS*32 bits.
  - One 32-bit counter per port, incremented on each accepted tlast beat from that port.
  - Wraps 0xFFFFFFFF -> 0.
  - Reset to 0.
- Undefined: port absent; no counter logic.

Decomposition:
- Shared package axis_sched_pkg:
  - FSM state encoding (IDLE = 1'b0, XFER = 1'b1).
  - Grant index width constant (3).
  - Default DATA_WIDTH/KEEP_WIDTH constants.
- One natural sub-module, rr_arbiter:
  - Combinational PORTS-wide rotate/priority-encode from request vector plus pointer.
  - Outputs index and found flag.
  - Instantiated once.

Test Plan:
- Single requester: port 2 sends a 3-beat frame (tkeep FF, FF, 0F), output_axis_tready = 1.
  - tready[2] rises 1 cycle after tvalid.
  - Output reproduces the 3 beats 1 cycle delayed, tlast on beat 3.
  - grant_port = 2; grant_active falls after the tlast handshake.
- Fairness: ports 0, 1 and 3 each hold continuous 2-beat frames.
  - Output frame order is 0, 1, 3, 0, 1, 3; no interleaving of beats.
- Backpressure: output_axis_tready toggles 1010 during a 4-beat frame from port 1.
  - Data is held stable while stalled; no beat is lost or duplicated.
  - tready[1] = 0 whenever the output register is full and stalled.
- Mid-frame gap: port 0 drops tvalid for 5 cycles within a frame while port 1 requests.
  - Grant stays on port 0; port 1 is served only after port 0's tlast.
- Async reset: assert rst_n = 0 mid-frame, asynchronously to clk.
  - output_axis_tvalid and all tready bits go 0 immediately.
  - After release, a port 3 request is granted; the pointer is back at 0 but port 3 is the only requester.
- With AXIS_TX_SCHED_STATS_EN: port 1 sends 5 frames and port 2 sends 2 frames.
  - frame_count reads 0, 5, 2, 0.
  - A counter preloaded via force to 0xFFFFFFFF wraps to 0 on the next frame.

Source files
------------

// File: rtl/axis_sched_pkg.sv
// Shared types and constants for the frame-granular AXI-stream TX scheduler.
package axis_sched_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_e;

  localparam int GRANT_W        = 3;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
endpackage

// File: rtl/axis_tx_sched_64_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping modulo PORTS.
// Purely combinational, zero latency; no flow control of its own.
module rr_arbiter
  import axis_sched_pkg::*;
#(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0]   req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [GRANT_W-1:0] idx_o,
  output logic               found_o
);

  logic [2*PORTS-1:0] rot;
  logic [GRANT_W-1:0] off;
  logic [GRANT_W:0]   sum;

  always_comb begin
    // Doubling the vector turns the wrap into a plain right shift.
    rot     = {req_i, req_i} >> ptr_i;
    found_o = 1'b0;
    off     = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        off     = GRANT_W'(k);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (GRANT_W + 1)'(PORTS)) begin
      sum = sum - (GRANT_W + 1)'(PORTS);
    end
    idx_o = sum[GRANT_W-1:0];
  end

endmodule

// File: rtl/axis_tx_sched_64.sv
// Frame-granular RR scheduler onto one AXI-stream TX path; 1-cycle request-to-ready and input-to-output latency.
// Backpressure: granted tready = ~out_valid | out_ready; optional per-port frame counters under AXIS_TX_SCHED_STATS_EN.
module axis_tx_sched_64
  import axis_sched_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       output_axis_tkeep,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  output logic                        grant_active,
  output logic [GRANT_W-1:0]          grant_port
`ifdef AXIS_TX_SCHED_STATS_EN
  ,
  output logic [PORTS*32-1:0]         frame_count
`endif
);

  localparam logic [GRANT_W-1:0] LAST_PORT = GRANT_W'(PORTS - 1);

  sched_state_e       state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;

  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] out_dat_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic                  out_user_q;

  logic                  sel_vld, sel_last, sel_user;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  in_rdy, in_hs;
  logic [GRANT_W-1:0]    arb_idx;
  logic                  arb_found;

  rr_arbiter #(.PORTS(PORTS)) u_arb (
    .req_i   (input_axis_tvalid),
    .ptr_i   (ptr_q),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  always_comb begin
    sel_vld  = 1'b0;
    sel_dat  = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    sel_user = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_vld  = input_axis_tvalid[i];
        sel_dat  = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep = input_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_last = input_axis_tlast[i];
        sel_user = input_axis_tuser[i];
      end
    end
  end

  assign in_rdy = ~out_vld_q | output_axis_tready;
  assign in_hs  = (state_q == XFER) & sel_vld & in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        if (in_hs && sel_last) begin
          ptr_d   = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    input_axis_tready = '0;
    if (state_q == XFER) begin
      for (int i = 0; i < PORTS; i++) begin
        if (grant_q == GRANT_W'(i)) begin
          input_axis_tready[i] = in_rdy;
        end
      end
    end
  end

  // Single skid-free output stage: load on handshake, drop valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_user_q <= 1'b0;
    end else if (in_hs) begin
      out_vld_q  <= 1'b1;
      out_dat_q  <= sel_dat;
      out_keep_q <= sel_keep;
      out_last_q <= sel_last;
      out_user_q <= sel_user;
    end else if (output_axis_tready) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign output_axis_tdata  = out_dat_q;
  assign output_axis_tkeep  = out_keep_q;
  assign output_axis_tvalid = out_vld_q;
  assign output_axis_tlast  = out_last_q;
  assign output_axis_tuser  = out_user_q;
  assign grant_active       = (state_q == XFER);
  assign grant_port         = grant_q;

`ifdef AXIS_TX_SCHED_STATS_EN
  for (genvar i = 0; i < PORTS; i++) begin : g_stats
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (in_hs && sel_last && (grant_q == GRANT_W'(i))) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign frame_count[i*32 +: 32] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_axis_tx_sched_64.sv
// Directed bench for axis_tx_sched_64 with per-port source queues and an output scoreboard.
module tb_axis_tx_sched_64;
  localparam int PORTS = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic                 clk;
  logic                 rst_n;
  logic [PORTS*64-1:0]  in_tdata;
  logic [PORTS*8-1:0]   in_tkeep;
  logic [PORTS-1:0]     in_tvalid;
  logic [PORTS-1:0]     in_tready;
  logic [PORTS-1:0]     in_tlast;
  logic [PORTS-1:0]     in_tuser;
  logic [63:0]          out_tdata;
  logic [7:0]           out_tkeep;
  logic                 out_vld;
  logic                 out_rdy;
  logic                 out_tlast;
  logic                 out_tuser;
  logic                 grant_active;
  logic [2:0]           grant_port;
`ifdef AXIS_TX_SCHED_STATS_EN
  logic [PORTS*32-1:0]  frame_count;
`endif

  axis_tx_sched_64 #(.PORTS(PORTS), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_axis_tdata   (in_tdata),
    .input_axis_tkeep   (in_tkeep),
    .input_axis_tvalid  (in_tvalid),
    .input_axis_tready  (in_tready),
    .input_axis_tlast   (in_tlast),
    .input_axis_tuser   (in_tuser),
    .output_axis_tdata  (out_tdata),
    .output_axis_tkeep  (out_tkeep),
    .output_axis_tvalid (out_vld),
    .output_axis_tready (out_rdy),
    .output_axis_tlast  (out_tlast),
    .output_axis_tuser  (out_tuser),
    .grant_active       (grant_active),
    .grant_port         (grant_port)
`ifdef AXIS_TX_SCHED_STATS_EN
    ,
    .frame_count        (frame_count)
`endif
  );

  beat_t      src_q [PORTS][$];
  beat_t      exp_q [$];
  logic [3:0] gap;
  logic       bp_mode;
  int         n_tests;
  int         n_fail;
  int         fid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int p, input int n, input logic [7:0] last_keep, input logic user);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {8'(p), 24'(fid), 32'(i)};
      b.k = (i == n - 1) ? last_keep : 8'hFF;
      b.l = (i == n - 1);
      b.u = user;
      src_q[p].push_back(b);
      exp_q.push_back(b);
    end
    fid++;
  endtask

  function automatic int pending();
    int s = exp_q.size();
    for (int p = 0; p < PORTS; p++) s += src_q[p].size();
    return s;
  endfunction

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(pending()), 128'd0);
  endtask

  task automatic flush();
    for (int p = 0; p < PORTS; p++) src_q[p].delete();
    exp_q.delete();
  endtask

  // Source driver: handshakes sampled at negedge, new beats presented just after posedge.
  initial begin
    logic [PORTS-1:0] hs;
    in_tvalid = '0;
    in_tdata  = '0;
    in_tkeep  = '0;
    in_tlast  = '0;
    in_tuser  = '0;
    out_rdy   = 1'b1;
    forever begin
      @(negedge clk);
      hs = in_tvalid & in_tready;
      @(posedge clk);
      #1;
      out_rdy = bp_mode ? ~out_rdy : 1'b1;
      for (int p = 0; p < PORTS; p++) begin
        if (hs[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
        if (!gap[p] && src_q[p].size() != 0) begin
          in_tvalid[p]          = 1'b1;
          in_tdata[p*64 +: 64]  = src_q[p][0].d;
          in_tkeep[p*8 +: 8]    = src_q[p][0].k;
          in_tlast[p]           = src_q[p][0].l;
          in_tuser[p]           = src_q[p][0].u;
        end else begin
          in_tvalid[p] = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard pop on every accepted beat, plus stall-hold rules.
  initial begin
    beat_t cur, prev_beat, e;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = {out_tdata, out_tkeep, out_tlast, out_tuser};
        if (prev_stall) begin
          chk("stall_vld", 128'(out_vld), 128'd1);
          chk("stall_hold", 128'(cur), 128'(prev_beat));
        end
        if (out_vld && !out_rdy) chk("rdy_while_stalled", 128'(in_tready), 128'd0);
        if (out_vld && out_rdy) begin
          chk("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", 128'(cur), 128'(e));
          end
        end
        prev_stall = out_vld & ~out_rdy;
        prev_beat  = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fid     = 0;
    gap     = '0;
    bp_mode = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_vld", 128'(out_vld), 128'd0);
    chk("rst_tready", 128'(in_tready), 128'd0);
    chk("rst_grant_active", 128'(grant_active), 128'd0);
    chk("rst_grant_port", 128'(grant_port), 128'd0);
    chk("rst_tdata", 128'(out_tdata), 128'd0);
    negs(3);
    rst_n = 1'b1;
    negs(2);

    // Fairness: ports 0,1,3 each queue two 2-beat frames; RR from pointer 0.
    add_frame(0, 2, 8'hFF, 1'b0);
    add_frame(1, 2, 8'hFF, 1'b0);
    add_frame(3, 2, 8'hFF, 1'b0);
    add_frame(0, 2, 8'hFF, 1'b0);
    add_frame(1, 2, 8'hFF, 1'b0);
    add_frame(3, 2, 8'hFF, 1'b0);
    drain("fair_drain", 200);
    negs(2);

    // Single requester port 2, 3 beats, keep FF/FF/0F, tuser set on the frame.
    add_frame(2, 3, 8'h0F, 1'b1);
    negs(1);
    chk("t1_vld_seen", 128'(in_tvalid), 128'b0100);
    chk("t1_rdy_lat0", 128'(in_tready), 128'd0);
    negs(1);
    chk("t1_rdy_lat1", 128'(in_tready), 128'b0100);
    chk("t1_grant_active", 128'(grant_active), 128'd1);
    chk("t1_grant_port", 128'(grant_port), 128'd2);
    negs(1);
    chk("t1_out_lat", 128'(out_vld), 128'd1);
    negs(2);
    chk("t1_active_fall", 128'(grant_active), 128'd0);
    chk("t1_port_hold", 128'(grant_port), 128'd2);
    drain("t1_drain", 50);

    // Backpressure: output ready toggles every cycle during a 4-beat frame from port 1.
    bp_mode = 1'b1;
    add_frame(1, 4, 8'h3F, 1'b0);
    drain("bp_drain", 100);
    bp_mode = 1'b0;
    negs(3);

    // Mid-frame gap on port 0 while port 1 requests.
    add_frame(0, 4, 8'hFF, 1'b0);
    negs(3);
    gap[0] = 1'b1;
    add_frame(1, 2, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      negs(1);
      chk("gap_grant_port", 128'(grant_port), 128'd0);
      chk("gap_grant_active", 128'(grant_active), 128'd1);
      chk("gap_p1_rdy", 128'(in_tready[1]), 128'd0);
    end
    gap[0] = 1'b0;
    drain("gap_drain", 100);
    negs(2);

    // Asynchronous reset mid-frame.
    add_frame(2, 6, 8'hFF, 1'b0);
    negs(4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", 128'(out_vld), 128'd0);
    chk("arst_tready", 128'(in_tready), 128'd0);
    chk("arst_grant_active", 128'(grant_active), 128'd0);
    flush();
    negs(2);
    rst_n = 1'b1;
    add_frame(3, 1, 8'h07, 1'b0);
    negs(2);
    chk("arst_p3_grant", 128'(grant_port), 128'd3);
    chk("arst_p3_rdy", 128'(in_tready), 128'b1000);
    negs(1);
    chk("single_beat_done", 128'(grant_active), 128'd0);
    drain("arst_drain", 50);

`ifdef AXIS_TX_SCHED_STATS_EN
    rst_n = 1'b0;
    negs(2);
    rst_n = 1'b1;
    negs(1);
    for (int i = 0; i < 5; i++) add_frame(1, 2, 8'hFF, 1'b0);
    for (int i = 0; i < 2; i++) add_frame(2, 1, 8'hFF, 1'b0);
    drain("stats_drain", 200);
    negs(2);
    chk("cnt0", 128'(frame_count[0 +: 32]), 128'd0);
    chk("cnt1", 128'(frame_count[32 +: 32]), 128'd5);
    chk("cnt2", 128'(frame_count[64 +: 32]), 128'd2);
    chk("cnt3", 128'(frame_count[96 +: 32]), 128'd0);
    force dut.g_stats[0].cnt_q = 32'hFFFF_FFFF;
    #1 release dut.g_stats[0].cnt_q;
    negs(1);
    chk("cnt0_preload", 128'(frame_count[0 +: 32]), 128'hFFFF_FFFF);
    add_frame(0, 1, 8'hFF, 1'b0);
    drain("wrap_drain", 50);
    negs(1);
    chk("cnt0_wrap", 128'(frame_count[0 +: 32]), 128'd0);
`endif

    negs(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
